p4_out_meta_router: RTL and testbench

//  Egress stage after the P4 pipeline in the 250 MHz box. Queues per-packet user metadata,

---
 rtl/p4_out_pkg.sv | 15 +
 rtl/p4_meta_fifo.sv | 61 ++++++
 rtl/p4_out_meta_router.sv | 170 +++++++++++++++++
 tb/tb_p4_out_meta_router.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/p4_out_pkg.sv
// Shared field offsets and FSM encoding for the P4 egress metadata router.
package p4_out_pkg;

    localparam int META_USER_LSB = 0;
    localparam int META_LEN_LSB  = 16;
    localparam int META_DEST_LSB = 32;
    localparam int META_FIELD_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } state_e;

endpackage

// File: rtl/p4_meta_fifo.sv
// Show-ahead synchronous FIFO holding the reduced per-packet metadata words.
// A push while full is discarded and latches a sticky overflow flag.
module p4_meta_fifo #(
    parameter int WIDTH = 49,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             ovf_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    // A simultaneous pop frees the head slot, so a push is accepted even when full.
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign ovf_o   = ovf_q;

    always_comb begin
        wr_ptr_d = do_push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = do_pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        ovf_d    = ovf_q | (push_i && !do_push);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/p4_out_meta_router.sv
// Egress stage after the P4 pipeline: pairs each queued metadata word with one packet
// and steers that packet to one AXIS port or drops it.
module p4_out_meta_router
    import p4_out_pkg::*;
#(
    parameter int TDATA_W    = 1024,
    parameter int USERMETA_W = 1088,
    parameter int NUM_PORTS  = 2,
    parameter int META_DEPTH = 16,
    parameter int DROP_BIT   = 48
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic [TDATA_W-1:0]      s_axis_tdata,
    input  logic [TDATA_W/8-1:0]    s_axis_tkeep,
    input  logic                    s_axis_tlast,
    input  logic [USERMETA_W-1:0]   user_metadata_out,
    input  logic                    user_metadata_out_valid,
    output logic [NUM_PORTS-1:0]    m_axis_tvalid,
    output logic [TDATA_W-1:0]      m_axis_tdata,
    output logic [TDATA_W/8-1:0]    m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic [15:0]             m_axis_tdest,
    output logic [127:0]            m_axis_tuser,
    input  logic [NUM_PORTS-1:0]    m_axis_tready,
    output logic [31:0]             pkt_fwd_cnt,
    output logic [31:0]             pkt_drop_cnt,
    output logic                    meta_ovf
);

    localparam int          FIFO_W = 3 * META_FIELD_W + 1;
    localparam logic [3:0]  NP     = 4'(NUM_PORTS);

    logic [1:0]         rst_sync_q;
    logic               rst_n;
    logic               meta_unused;

    logic [FIFO_W-1:0]  fifo_din, fifo_dout;
    logic               fifo_full, fifo_empty, fifo_pop;

    logic [15:0]        head_usr, head_len, head_dest;
    logic               head_drop;
    logic               beat_hs;

    state_e             state_q, state_d;
    logic [2:0]         port_q, port_d;
    logic [15:0]        tdest_q, tdest_d;
    logic [127:0]       tuser_q, tuser_d;
    logic [31:0]        fwd_cnt_q, fwd_cnt_d;
    logic [31:0]        drop_cnt_q, drop_cnt_d;

    // Reset asserts immediately but is released two clocks after aresetn rises.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_n = rst_sync_q[1];

    // Only user/len/dest and the drop flag ever leave the FIFO.
    assign meta_unused = ^user_metadata_out;
    assign fifo_din = {user_metadata_out[DROP_BIT], user_metadata_out[META_DEST_LSB +: META_FIELD_W],
                       user_metadata_out[META_LEN_LSB +: META_FIELD_W],
                       user_metadata_out[META_USER_LSB +: META_FIELD_W]};

    p4_meta_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (META_DEPTH)
    ) u_meta_fifo (
        .clk_i   (aclk),
        .rst_ni  (rst_n),
        .push_i  (user_metadata_out_valid),
        .din_i   (fifo_din),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .ovf_o   (meta_ovf)
    );

    assign head_usr  = fifo_dout[0 +: 16];
    assign head_len  = fifo_dout[16 +: 16];
    assign head_dest = fifo_dout[32 +: 16];
    assign head_drop = fifo_dout[48];
    assign beat_hs   = s_axis_tvalid && s_axis_tready;

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            port_q     <= '0;
            tdest_q    <= '0;
            tuser_q    <= '0;
            fwd_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            port_q     <= port_d;
            tdest_q    <= tdest_d;
            tuser_q    <= tuser_d;
            fwd_cnt_q  <= fwd_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        port_d     = port_q;
        tdest_d    = tdest_q;
        tuser_d    = tuser_q;
        fwd_cnt_d  = fwd_cnt_q;
        drop_cnt_d = drop_cnt_q;
        fifo_pop   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // The pairing decision costs one bubble cycle per packet.
                if (!fifo_empty && s_axis_tvalid) begin
                    fifo_pop = 1'b1;
                    port_d   = head_dest[2:0];
                    tdest_d  = head_dest;
                    tuser_d  = {32'd0, head_len, head_usr, 32'd0, head_len, head_usr};
                    state_d  = (head_drop || ({1'b0, head_dest[2:0]} >= NP)) ? ST_DROP : ST_FWD;
                end
            end
            ST_FWD: begin
                if (beat_hs && s_axis_tlast) begin
                    fwd_cnt_d = fwd_cnt_q + 32'd1;
                    state_d   = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (beat_hs && s_axis_tlast) begin
                    drop_cnt_d = drop_cnt_q + 32'd1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Valid depends only on state and s_axis_tvalid, never on downstream ready.
    always_comb begin
        s_axis_tready = 1'b0;
        m_axis_tvalid = '0;
        unique case (state_q)
            ST_FWD: begin
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (port_q == 3'(p)) begin
                        m_axis_tvalid[p] = s_axis_tvalid;
                        s_axis_tready    = m_axis_tready[p];
                    end
                end
            end
            ST_DROP: s_axis_tready = 1'b1;
            default: s_axis_tready = 1'b0;
        endcase
    end

    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tkeep  = s_axis_tkeep;
    assign m_axis_tlast  = s_axis_tlast;
    assign m_axis_tdest  = tdest_q;
    assign m_axis_tuser  = tuser_q;
    assign pkt_fwd_cnt   = fwd_cnt_q;
    assign pkt_drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_p4_out_meta_router.sv
// Randomized bench for p4_out_meta_router with a transaction-level expectation per packet.
module tb_p4_out_meta_router;

    localparam int TW = 64;
    localparam int KW = TW / 8;
    localparam int UW = 64;
    localparam int NP = 2;
    localparam int MD = 16;

    logic            aclk = 1'b0;
    logic            aresetn;
    logic            s_axis_tvalid;
    logic            s_axis_tready;
    logic [TW-1:0]   s_axis_tdata;
    logic [KW-1:0]   s_axis_tkeep;
    logic            s_axis_tlast;
    logic [UW-1:0]   user_metadata_out;
    logic            user_metadata_out_valid;
    logic [NP-1:0]   m_axis_tvalid;
    logic [TW-1:0]   m_axis_tdata;
    logic [KW-1:0]   m_axis_tkeep;
    logic            m_axis_tlast;
    logic [15:0]     m_axis_tdest;
    logic [127:0]    m_axis_tuser;
    logic [NP-1:0]   m_axis_tready;
    logic [31:0]     pkt_fwd_cnt;
    logic [31:0]     pkt_drop_cnt;
    logic            meta_ovf;

    int errors = 0;
    int checks = 0;
    int exp_fwd = 0;
    int exp_drop = 0;

    p4_out_meta_router #(
        .TDATA_W    (TW),
        .USERMETA_W (UW),
        .NUM_PORTS  (NP),
        .META_DEPTH (MD),
        .DROP_BIT   (48)
    ) dut (
        .aclk                    (aclk),
        .aresetn                 (aresetn),
        .s_axis_tvalid           (s_axis_tvalid),
        .s_axis_tready           (s_axis_tready),
        .s_axis_tdata            (s_axis_tdata),
        .s_axis_tkeep            (s_axis_tkeep),
        .s_axis_tlast            (s_axis_tlast),
        .user_metadata_out       (user_metadata_out),
        .user_metadata_out_valid (user_metadata_out_valid),
        .m_axis_tvalid           (m_axis_tvalid),
        .m_axis_tdata            (m_axis_tdata),
        .m_axis_tkeep            (m_axis_tkeep),
        .m_axis_tlast            (m_axis_tlast),
        .m_axis_tdest            (m_axis_tdest),
        .m_axis_tuser            (m_axis_tuser),
        .m_axis_tready           (m_axis_tready),
        .pkt_fwd_cnt             (pkt_fwd_cnt),
        .pkt_drop_cnt            (pkt_drop_cnt),
        .meta_ovf                (meta_ovf)
    );

    always #2 aclk = ~aclk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] make_meta(input logic [15:0] dest, input logic [15:0] len,
                                              input logic [15:0] usr, input logic drop);
        logic [63:0] m;
        m        = {$urandom, $urandom};
        m[15:0]  = usr;
        m[31:16] = len;
        m[47:32] = dest;
        m[48]    = drop;
        return m;
    endfunction

    task automatic push_meta(input logic [63:0] m);
        user_metadata_out       = m;
        user_metadata_out_valid = 1'b1;
        @(posedge aclk); #1;
        user_metadata_out_valid = 1'b0;
    endtask

    // Offers one packet of nb beats. mdelay>=0 strobes its metadata on that cycle of the
    // packet; mdelay<0 means the metadata is already queued. stall holds ready low 10 cycles.
    task automatic run_pkt(input int nb, input int mdelay, input logic [63:0] meta,
                           input bit stall, output logic [127:0] seen_user);
        logic [TW-1:0] data [$];
        logic [KW-1:0] keep [$];
        logic [15:0]   e_dest;
        logic [63:0]   half;
        logic [127:0]  e_user;
        logic [NP-1:0] onehot;
        int            e_port;
        bit            e_drop;
        bit            hs;
        bit            legal;
        int            beat;
        int            cyc;
        int            stall_left;

        e_dest = meta[47:32];
        e_port = e_dest % 8;
        e_drop = meta[48] || (e_port >= NP);
        half   = {32'd0, meta[31:16], meta[15:0]};
        e_user = {half, half};
        onehot = e_drop ? '0 : (NP'(1) << e_port);
        seen_user = '0;
        for (int i = 0; i < nb; i++) begin
            data.push_back({$urandom, $urandom});
            keep.push_back(KW'($urandom));
        end
        beat = 0;
        cyc = 0;
        stall_left = 0;
        s_axis_tvalid = 1'b0;
        while (beat < nb && cyc <= 400) begin
            user_metadata_out_valid = (cyc == mdelay);
            user_metadata_out = (cyc == mdelay) ? meta : {$urandom, $urandom};
            if (stall_left > 0) s_axis_tvalid = 1'b1;
            else if (!s_axis_tvalid) s_axis_tvalid = ($urandom_range(0, 3) != 0);
            s_axis_tdata = data[beat];
            s_axis_tkeep = keep[beat];
            s_axis_tlast = (beat == nb - 1);
            for (int p = 0; p < NP; p++) m_axis_tready[p] = (stall_left == 0) && ($urandom_range(0, 3) != 0);
            @(negedge aclk);
            hs = s_axis_tvalid && s_axis_tready;
            legal = (m_axis_tvalid == '0) || (!e_drop && m_axis_tvalid == onehot && s_axis_tvalid);
            check("mvalid_legal", legal, 1'b1);
            if (!e_drop) check("ready_from_sel", s_axis_tready && !m_axis_tready[e_port], 1'b0);
            if (!e_drop && beat > 0) check("mvalid_follow", m_axis_tvalid, s_axis_tvalid ? onehot : '0);
            if (e_drop && beat > 0) check("drop_ready", s_axis_tready, 1'b1);
            if (stall_left > 0) check("stall_ready", s_axis_tready, 1'b0);
            if (m_axis_tvalid != '0) begin
                check("m_tdata", m_axis_tdata, data[beat]);
                check("m_tkeep", m_axis_tkeep, keep[beat]);
                check("m_tlast", m_axis_tlast, beat == nb - 1);
                check("m_tdest", m_axis_tdest, e_dest);
                check("m_tuser", m_axis_tuser, e_user);
                seen_user = m_axis_tuser;
            end
            if (hs) begin
                if (mdelay >= 0) check("early_beat", cyc < mdelay + 2, 1'b0);
                check("hs_mvalid", m_axis_tvalid, onehot);
            end
            @(posedge aclk); #1;
            if (stall_left > 0) stall_left--;
            if (hs) begin
                beat++;
                s_axis_tvalid = 1'b0;
                if (stall && beat == 1 && !e_drop) stall_left = 10;
            end
            cyc++;
        end
        s_axis_tvalid = 1'b0;
        user_metadata_out_valid = 1'b0;
        check("pkt_complete", beat, nb);
        if (e_drop) exp_drop++;
        else exp_fwd++;
        check("fwd_cnt", pkt_fwd_cnt, exp_fwd);
        check("drop_cnt", pkt_drop_cnt, exp_drop);
    endtask

    logic [63:0]  qmeta [MD];
    logic [127:0] u;
    int           hs_cnt;

    initial begin
        aresetn = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata = '0;
        s_axis_tkeep = '0;
        s_axis_tlast = 1'b0;
        user_metadata_out = '0;
        user_metadata_out_valid = 1'b0;
        m_axis_tready = '0;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_s_tready", s_axis_tready, 1'b0);
        check("rst_m_tvalid", m_axis_tvalid, '0);
        check("rst_fwd_cnt", pkt_fwd_cnt, 0);
        check("rst_drop_cnt", pkt_drop_cnt, 0);
        check("rst_ovf", meta_ovf, 1'b0);
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (4) @(posedge aclk);
        #1;

        // Single-beat forward to port 1 with the literal tuser layout.
        run_pkt(1, 0, make_meta(16'd1, 16'h0040, 16'h00AA, 1'b0), 1'b0, u);
        check("t1_tuser", u, 128'h0000_0000_0040_00AA_0000_0000_0040_00AA);
        // Drop by flag, then drop by out-of-range port.
        run_pkt(3, 1, make_meta(16'd0, 16'h0010, 16'h1234, 1'b1), 1'b0, u);
        run_pkt(2, 2, make_meta(16'd5, 16'h0020, 16'h5678, 1'b0), 1'b0, u);

        // Overfill the metadata queue, then drain it with packets in order.
        for (int i = 0; i < MD; i++) begin
            qmeta[i] = make_meta({13'($urandom), 3'($urandom_range(0, 2))}, 16'($urandom), 16'($urandom), 1'b0);
            push_meta(qmeta[i]);
        end
        check("ovf_at_full", meta_ovf, 1'b0);
        push_meta(make_meta(16'hBEEF, 16'h0, 16'h0, 1'b0));
        check("ovf_set", meta_ovf, 1'b1);
        for (int i = 0; i < MD; i++) begin
            run_pkt($urandom_range(1, 3), -1, qmeta[i], 1'b0, u);
        end
        check("ovf_sticky", meta_ovf, 1'b1);

        // Long downstream stall mid-packet on port 0.
        run_pkt(4, 2, make_meta(16'd0, 16'h0100, 16'h0F0F, 1'b0), 1'b1, u);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            run_pkt($urandom_range(1, 5), $urandom_range(0, 4),
                    make_meta(16'($urandom), 16'($urandom), 16'($urandom), $urandom_range(0, 3) == 0),
                    ($urandom_range(0, 7) == 0), u);
        end

        // Reset on beat 2 of a 4-beat packet.
        push_meta(make_meta(16'd0, 16'h0004, 16'h0001, 1'b0));
        m_axis_tready = '1;
        s_axis_tvalid = 1'b1;
        s_axis_tlast = 1'b0;
        hs_cnt = 0;
        for (int c = 0; c < 20 && hs_cnt == 0; c++) begin
            @(negedge aclk);
            if (s_axis_tvalid && s_axis_tready) hs_cnt++;
            @(posedge aclk); #1;
        end
        check("pre_reset_beat", hs_cnt, 1);
        s_axis_tdata = {$urandom, $urandom};
        @(negedge aclk);
        aresetn = 1'b0;
        @(posedge aclk); #1;
        check("mid_rst_s_tready", s_axis_tready, 1'b0);
        check("mid_rst_m_tvalid", m_axis_tvalid, '0);
        check("mid_rst_fwd_cnt", pkt_fwd_cnt, 0);
        check("mid_rst_drop_cnt", pkt_drop_cnt, 0);
        check("mid_rst_ovf", meta_ovf, 1'b0);
        @(posedge aclk); #1;
        s_axis_tvalid = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (4) @(posedge aclk);
        #1;
        exp_fwd = 0;
        exp_drop = 0;
        run_pkt(2, 3, make_meta(16'd0, 16'h0002, 16'h0077, 1'b0), 1'b0, u);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
